// File: rtl/laser_pkg.sv
// Shared definitions for the LASER search core and its coverage evaluator:
// pattern geometry, point type, load/wait state encoding and a distance helper.
package laser_pkg;

    localparam int unsigned NUM_PTS   = 40;
    localparam int unsigned COORD_W   = 4;
    localparam int unsigned RADIUS_SQ = 16;
    localparam int unsigned IDX_W     = 6;
    localparam int unsigned COVER_W   = 6;
    localparam int unsigned DSQ_W     = 2 * COORD_W + 1;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } point_t;

    typedef enum logic {
        LOAD = 1'b0,
        WAIT = 1'b1
    } state_t;

    // Squared Euclidean distance; each square fits 8 bits, the sum needs 9.
    function automatic logic [DSQ_W-1:0] dist_sq(input point_t c, input point_t p);
        logic [COORD_W-1:0]   dx;
        logic [COORD_W-1:0]   dy;
        logic [2*COORD_W-1:0] sx;
        logic [2*COORD_W-1:0] sy;
        dx = (c.x >= p.x) ? (c.x - p.x) : (p.x - c.x);
        dy = (c.y >= p.y) ? (c.y - p.y) : (p.y - c.y);
        sx = {{COORD_W{1'b0}}, dx} * {{COORD_W{1'b0}}, dx};
        sy = {{COORD_W{1'b0}}, dy} * {{COORD_W{1'b0}}, dy};
        return {1'b0, sx} + {1'b0, sy};
    endfunction

endpackage

// File: rtl/laser_dist_chk.sv
// Combinational coverage test: a point is hit when it lies within the
// inclusive radius of either centre; overlap still yields a single hit.
module laser_dist_chk
    import laser_pkg::*;
(
    input  point_t c1,
    input  point_t c2,
    input  point_t p,
    output logic   hit
);

    localparam logic [DSQ_W-1:0] R_SQ = DSQ_W'(RADIUS_SQ);

    always_comb begin
        hit = (dist_sq(c1, p) <= R_SQ) || (dist_sq(c2, p) <= R_SQ);
    end

endmodule

// File: rtl/laser_cover_eval.sv
// Snoops the core's point stream, and while loading the next pattern scores
// the previous one against the circle pair returned with DONE.
module laser_cover_eval
    import laser_pkg::*;
(
    input  logic               CLK,
    input  logic               RST,
    input  logic [COORD_W-1:0] X,
    input  logic [COORD_W-1:0] Y,
    input  logic               DONE,
    input  logic [COORD_W-1:0] C1X,
    input  logic [COORD_W-1:0] C1Y,
    input  logic [COORD_W-1:0] C2X,
    input  logic [COORD_W-1:0] C2Y,
    output logic [COVER_W-1:0] COVER,
    output logic               COVER_VALID,
    output logic               ERR
);

    state_t             state;
    point_t             pt [NUM_PTS];
    logic [IDX_W-1:0]   idx;
    logic               scr;
    point_t             c1;
    point_t             c2;
    logic [COVER_W-1:0] acc;
    point_t             old_pt;
    logic               hit;
    logic               last;
    logic               load_en;

    always_comb begin
        old_pt = pt[0];
        if (idx < IDX_W'(NUM_PTS)) begin
            old_pt = pt[idx];
        end
    end

    assign last    = (idx == IDX_W'(NUM_PTS - 1));
    assign load_en = (state == LOAD) && !DONE;

    laser_dist_chk u_dist_chk (
        .c1  (c1),
        .c2  (c2),
        .p   (old_pt),
        .hit (hit)
    );

    // Old entry is scored in the same cycle it is overwritten by the new point.
    always_ff @(posedge CLK) begin
        if (!RST && load_en) begin
            pt[idx] <= {X, Y};
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= LOAD;
            idx         <= '0;
            scr         <= 1'b0;
            acc         <= '0;
            c1          <= '0;
            c2          <= '0;
            COVER       <= '0;
            COVER_VALID <= 1'b0;
            ERR         <= 1'b0;
        end else begin
            COVER_VALID <= 1'b0;
            if (state == LOAD) begin
                if (DONE) begin
                    // idx==0 covers DONE still asserted after the handshake.
                    if (idx != '0) begin
                        ERR <= 1'b1;
                    end
                end else begin
                    idx <= idx + IDX_W'(1);
                    if (scr) begin
                        acc <= acc + COVER_W'(hit);
                    end
                    if (last) begin
                        state <= WAIT;
                        scr   <= 1'b0;
                        if (scr) begin
                            COVER       <= acc + COVER_W'(hit);
                            COVER_VALID <= 1'b1;
                        end
                    end
                end
            end else begin
                if (DONE) begin
                    c1    <= {C1X, C1Y};
                    c2    <= {C2X, C2Y};
                    scr   <= 1'b1;
                    idx   <= '0;
                    acc   <= '0;
                    state <= LOAD;
                end
            end
        end
    end

endmodule

// File: doc/laser_cover_eval.md
# laser_cover_eval

Coverage evaluator that sits alongside the LASER search core. It snoops the same X/Y point stream and captures each 40-point pattern. When the core raises DONE, it scores the returned circle pair (C1, C2) against the stored pattern and reports how many points fall within radius 4. The scoring runs in the cycles that load the next pattern, so it adds no extra cycles; the result feeds the on-chip self-check and performance counters.

## Interface
- NUM_PTS, 40: points per pattern.
- COORD_W, 4: coordinate width; grid is 16x16.
- RADIUS_SQ, 16: inclusive squared radius.
- CLK  in  1  clock; all logic on rising edge.
- RST  in  1  reset; synchronous, active-high.
- X  in  COORD_W  point x coordinate, same stream as the core.
- Y  in  COORD_W  point y coordinate.
- DONE  in  1  core's DONE output.
- C1X, C1Y, C2X, C2Y  in  COORD_W each  core's result centres; valid while DONE=1.
- COVER  out  6  covered-point count of last scored pattern (0..40).
- COVER_VALID  out  1  one-cycle pulse when COVER updates.
- ERR  out  1  sticky protocol error flag.

## Operation
- Storage: NUM_PTS x (2*COORD_W) register array `pt[]`, plus load index `idx` (0..NUM_PTS).
- Scoring flag `scr`: 1 when the current load pass also scores the previous pattern.
- Latched centre registers `c1`, `c2`, and a 6-bit accumulator `acc`.
- States:
  - LOAD: on each edge with DONE=0 and idx<NUM_PTS:
    - write `pt[idx] <= {X,Y}`;
    - if `scr`, add `hit(pt[idx])` to `acc`, where `pt[idx]` is the old entry read before the write in the same cycle;
    - `idx++`.
  - LOAD exit: when idx reaches NUM_PTS, go to WAIT.
    - If `scr`, load COVER <= final acc (including the last point) and pulse COVER_VALID.
    - Clear `scr`.
  - WAIT: hold `pt[]`. On the first edge with DONE=1:
    - latch C1/C2 into `c1`/`c2`;
    - set `scr=1`, `idx=0`, `acc=0`;
    - go to LOAD.
- `hit(p)` is 1 when (c1x−px)²+(c1y−py)² ≤ RADIUS_SQ OR the same holds for c2. A point covered by both circles counts once.
- Arithmetic:
  - |dx|, |dy| are COORD_W-bit unsigned; squares are 8 bits; their sum is 9 bits.
  - Compare is unsigned and inclusive; d²=16 is covered, d²=17 is not.
- DONE=1 in LOAD with idx==0: stall, no write, no score, no error. This covers DONE still high after a handshake.
- DONE=1 in LOAD with idx>0: stall, set ERR=1 (sticky until RST).
- DONE=1 on the same edge that idx reaches NUM_PTS: ignored. WAIT acts on it from the next edge.
- After RST: state LOAD, idx=0, scr=0. The first pattern after reset is loaded but not scored.
- RST mid-pass: aborts scoring, no COVER_VALID; COVER is cleared.

## Timing
- Reset values: COVER=0, COVER_VALID=0, ERR=0, idx=0, acc=0, state LOAD.
- First edge with RST=0 and DONE=0 samples point 0. 40 consecutive non-stalled edges load points 0..39.
- Let E be the edge where DONE=1 is sampled in WAIT. With no stalls, point k of the next pattern is written, and old point k scored, at edge E+1+k.
- COVER and COVER_VALID are registered at edge E+40 and visible in the following cycle. Latency from DONE is 40 cycles plus any stall cycles.
- COVER_VALID is high for exactly one cycle. COVER holds until the next valid update.
- C1/C2 are sampled only at edge E; later changes are ignored.

## Structure
- laser_pkg: NUM_PTS, COORD_W, RADIUS_SQ, point struct {x,y}, state enum {LOAD, WAIT}. Shared with the search core.
- Sub-module laser_dist_chk: combinational; inputs are two centres and one point; output is hit. The core reuses it for its own coverage counts.

## Test plan
- Reset, load 40× (0,0), DONE with C1=(0,0), C2=(15,15), then stream any pattern → COVER_VALID one cycle after edge E+40, COVER=40.
- Boundary: pattern is 20× (8,8) and 20× (0,0); C1=(8,4), C2=(5,0) → COVER=20 (d²=16 hits, d²=25 misses). Repeat with C1=(8,5), C2=(4,0) → COVER=40.
- Overlap: all 40 points at (7,7), C1=C2=(7,7) → COVER=40, not 80.
- DONE held high 3 extra cycles after E → idx stays 0, no writes, ERR=0; COVER_VALID 43 cycles after E with the correct count; `pt[]` equals the new pattern.
- DONE pulsed while idx=17 → ERR=1 and remains 1 through later patterns until RST; that edge performs no write.
- RST asserted at scoring point 20 → no COVER_VALID, COVER=0; the next pattern loads from index 0 with scr=0.
